// File: rtl/mioc_pkg.sv
// Shared types and defaults for the MIOC DRAM arbiter.
package mioc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    COL   = 3'd2,
    CAS   = 3'd3,
    RREF  = 3'd4,
    RHOLD = 3'd5,
    PRE   = 3'd6
  } arb_state_e;

  localparam int REF_INTERVAL_DEF = 60;
  localparam int REF_CNT_W_DEF    = 7;

  // BA15 value selecting each CAS strobe
  localparam logic BANK_CAS1 = 1'b0;
  localparam logic BANK_CAS2 = 1'b1;

endpackage

// File: rtl/dram_arb_if.sv
// Z80-side request signals and DRAM-side strobes of the MIOC DRAM arbiter.
interface dram_arb_if;
  logic bmreq_n;
  logic brfsh_n;
  logic brd_n;
  logic n_bwr;
  logic dma_n;
  logic ba15;
  logic ba14;
  logic ba7;
  logic ras_n;
  logic cas1_n;
  logic cas2_n;
  logic mux;
  logic ra7;
  logic wait_req_n;

  modport master (
    output bmreq_n, brfsh_n, brd_n, n_bwr, dma_n, ba15, ba14, ba7,
    input  ras_n, cas1_n, cas2_n, mux, ra7, wait_req_n
  );

  modport slave (
    input  bmreq_n, brfsh_n, brd_n, n_bwr, dma_n, ba15, ba14, ba7,
    output ras_n, cas1_n, cas2_n, mux, ra7, wait_req_n
  );
endinterface

// File: rtl/dram_ref_timer.sv
// DMA-time refresh timer, pending flag and refresh row counter.
// Only instantiated when MIOC_DMA_REFRESH_EN is defined.
module dram_ref_timer
  import mioc_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int REF_CNT_W    = REF_CNT_W_DEF
) (
  input  logic                 b_phi,
  input  logic                 rst_n,
  input  logic                 dma_n,
  input  logic                 ref_start,
  input  logic                 ref_done,
  output logic                 pending,
  output logic [REF_CNT_W-1:0] ref_cnt,
  output logic                 toggle
);

  localparam int TMR_W = $clog2(REF_INTERVAL + 1);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge b_phi or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      pending <= 1'b0;
      ref_cnt <= '0;
      toggle  <= 1'b0;
    end else begin
      // Any refresh restarts the interval; the count parks while pending is up.
      if (ref_start) begin
        timer   <= '0;
        pending <= 1'b0;
      end else if (!dma_n && !pending) begin
        timer <= timer + 1'b1;
        if (timer == TMR_W'(REF_INTERVAL - 1)) pending <= 1'b1;
      end
      if (ref_done) begin
        ref_cnt <= ref_cnt + 1'b1;
        if (&ref_cnt) toggle <= ~toggle;
      end
    end
  end

endmodule

// File: rtl/dram_arb.sv
// DRAM arbiter: RAS/CAS sequencing for Z80 accesses plus RAS-only refresh.
// MIOC_DMA_REFRESH_EN adds interval refresh while the 6801 DMA owns the bus.
//   state | meaning
//   IDLE  | waiting; refresh wins over an access
//   ROW   | RAS low, row address (BA14) on RA7
//   COL   | mux on column, BA7 on RA7
//   CAS   | latched bank's CAS low until BMREQ_N rises
//   RREF  | RAS-only refresh, refresh row MSB on RA7
//   RHOLD | refresh RAS hold
//   PRE   | one precharge cycle, all strobes high
module dram_arb
  import mioc_pkg::*;
#(
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int REF_CNT_W    = REF_CNT_W_DEF
) (
  input  logic      b_phi,
  input  logic      rst_n,
  dram_arb_if.slave bus
);

  arb_state_e state, state_nxt;
  logic bank;
  logic ras_nxt, cas1_nxt, cas2_nxt, mux_nxt, ra7_nxt, wait_nxt;
  logic access, z80_ref, pending, toggle, ref_start, ref_done;

  assign access    = !bus.bmreq_n && bus.brfsh_n && (!bus.brd_n || !bus.n_bwr);
  assign z80_ref   = !bus.bmreq_n && !bus.brfsh_n;
  assign ref_start = (state == IDLE) && (state_nxt == RREF);
  assign ref_done  = (state == RHOLD);

`ifdef MIOC_DMA_REFRESH_EN
  logic [REF_CNT_W-1:0] ref_cnt;

  dram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_CNT_W    (REF_CNT_W)
  ) u_ref_timer (
    .b_phi     (b_phi),
    .rst_n     (rst_n),
    .dma_n     (bus.dma_n),
    .ref_start (ref_start),
    .ref_done  (ref_done),
    .pending   (pending),
    .ref_cnt   (ref_cnt),
    .toggle    (toggle)
  );
`else
  logic [REF_CNT_W-1:0] ref_cnt;
  logic unused_dma_n;
  localparam int UNUSED_REF_INTERVAL = REF_INTERVAL;

  assign pending      = 1'b0;
  assign unused_dma_n = bus.dma_n;

  always_ff @(posedge b_phi or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      toggle  <= 1'b0;
    end else if (ref_done) begin
      ref_cnt <= ref_cnt + 1'b1;
      if (&ref_cnt) toggle <= ~toggle;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    ras_nxt   = 1'b1;
    cas1_nxt  = 1'b1;
    cas2_nxt  = 1'b1;
    mux_nxt   = 1'b0;
    ra7_nxt   = 1'b0;
    wait_nxt  = 1'b1;

    case (state)
      IDLE: begin
        if (z80_ref || pending) state_nxt = RREF;
        else if (access)        state_nxt = ROW;
      end
      ROW:   state_nxt = COL;
      COL:   state_nxt = CAS;
      CAS:   if (bus.bmreq_n) state_nxt = PRE;
      RREF:  state_nxt = RHOLD;
      RHOLD: state_nxt = PRE;
      PRE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_nxt)
      ROW: begin
        ras_nxt = 1'b0;
        ra7_nxt = bus.ba14;
      end
      COL: begin
        ras_nxt = 1'b0;
        mux_nxt = 1'b1;
        ra7_nxt = bus.ba7;
      end
      CAS: begin
        ras_nxt = 1'b0;
        mux_nxt = 1'b1;
        ra7_nxt = bus.ra7;
        if (bank == BANK_CAS1) cas1_nxt = 1'b0;
        else                   cas2_nxt = 1'b0;
      end
      RREF, RHOLD: begin
        ras_nxt = 1'b0;
        ra7_nxt = toggle;
      end
      default: ;
    endcase

`ifdef MIOC_DMA_REFRESH_EN
    if (access && (state_nxt == RREF || state_nxt == RHOLD ||
                   (state_nxt == PRE && state == RHOLD)))
      wait_nxt = 1'b0;
`endif
  end

  always_ff @(posedge b_phi or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bank           <= BANK_CAS1;
      bus.ras_n      <= 1'b1;
      bus.cas1_n     <= 1'b1;
      bus.cas2_n     <= 1'b1;
      bus.mux        <= 1'b0;
      bus.ra7        <= 1'b0;
      bus.wait_req_n <= 1'b1;
    end else begin
      state          <= state_nxt;
      bus.ras_n      <= ras_nxt;
      bus.cas1_n     <= cas1_nxt;
      bus.cas2_n     <= cas2_nxt;
      bus.mux        <= mux_nxt;
      bus.ra7        <= ra7_nxt;
      bus.wait_req_n <= wait_nxt;
      // Bank is frozen here so a late BA15 change cannot steer CAS.
      if (state == ROW) bank <= bus.ba15;
    end
  end

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb; DMA refresh scenarios run when MIOC_DMA_REFRESH_EN is defined.
module tb_dram_arb;

  logic b_phi = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  dram_arb_if bus();

  dram_arb dut (
    .b_phi (b_phi),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 b_phi = ~b_phi;

  // {ras_n, cas1_n, cas2_n, mux, ra7, wait_req_n}
  function automatic logic [5:0] obs();
    return {bus.ras_n, bus.cas1_n, bus.cas2_n, bus.mux, bus.ra7, bus.wait_req_n};
  endfunction

  task automatic step();
    @(posedge b_phi);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bmreq_n = 1'b1;
    bus.brfsh_n = 1'b1;
    bus.brd_n   = 1'b1;
    bus.n_bwr   = 1'b1;
    bus.dma_n   = 1'b1;
    bus.ba15    = 1'b0;
    bus.ba14    = 1'b0;
    bus.ba7     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge b_phi);
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 6'b111001) begin
      $display("FAIL reset_assert got %b want %b", obs(), 6'b111001);
      n_err++;
    end
    #20 rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs() !== 6'b111001) begin
      $display("FAIL reset_release got %b want %b", obs(), 6'b111001);
      n_err++;
    end
  endtask

  task automatic test_write();
    logic [5:0] exp_t [0:5];
    exp_t = '{6'b011001, 6'b011111, 6'b001111, 6'b001111, 6'b111001, 6'b111001};
    apply_reset();
    bus.ba15 = 1'b0; bus.ba14 = 1'b0; bus.ba7 = 1'b1;
    bus.bmreq_n = 1'b0; bus.n_bwr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL write cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 3) begin bus.bmreq_n = 1'b1; bus.n_bwr = 1'b1; end
    end
  endtask

  task automatic test_read_bank();
    logic [5:0] exp_t [0:4];
    exp_t = '{6'b011011, 6'b011101, 6'b010101, 6'b111001, 6'b111001};
    apply_reset();
    bus.ba15 = 1'b1; bus.ba14 = 1'b1; bus.ba7 = 1'b0;
    bus.bmreq_n = 1'b0; bus.brd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL read cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 1) bus.ba15 = 1'b0;
      if (i == 2) begin bus.bmreq_n = 1'b1; bus.brd_n = 1'b1; end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_t [0:8];
    exp_t = '{6'b011011, 6'b011101, 6'b001101, 6'b111001, 6'b111001,
              6'b011001, 6'b011111, 6'b010111, 6'b111001};
    apply_reset();
    bus.ba15 = 1'b0; bus.ba14 = 1'b1; bus.ba7 = 1'b0;
    bus.bmreq_n = 1'b0; bus.n_bwr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL back_to_back cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 2) begin bus.bmreq_n = 1'b1; bus.n_bwr = 1'b1; end
      if (i == 3) begin
        bus.ba15 = 1'b1; bus.ba14 = 1'b0; bus.ba7 = 1'b1;
        bus.bmreq_n = 1'b0; bus.brd_n = 1'b0;
      end
      if (i == 7) begin bus.bmreq_n = 1'b1; bus.brd_n = 1'b1; end
    end
  endtask

  task automatic test_refresh_priority();
    logic [5:0] exp_t [0:3];
    exp_t = '{6'b011001, 6'b011001, 6'b111001, 6'b111001};
    apply_reset();
    bus.bmreq_n = 1'b0; bus.brfsh_n = 1'b0; bus.brd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL refresh_prio cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 0) begin bus.bmreq_n = 1'b1; bus.brfsh_n = 1'b1; bus.brd_n = 1'b1; end
    end
  endtask

  // 385 refreshes: rows 1-128 RA7=0, 129-256 RA7=1, then the counter is back at 0.
  task automatic test_refresh_rows();
    logic [5:0] exp_v;
    apply_reset();
    for (int k = 1; k <= 385; k++) begin
      bus.bmreq_n = 1'b0; bus.brfsh_n = 1'b0;
      step();
      exp_v = {4'b0110, 1'(((k - 1) / 128) % 2), 1'b1};
      n_cmp++;
      if (obs() !== exp_v) begin
        $display("FAIL refresh_row%0d got %b want %b", k, obs(), exp_v);
        n_err++;
      end
      bus.bmreq_n = 1'b1; bus.brfsh_n = 1'b1;
      repeat (3) step();
    end
  endtask

  task automatic test_reset_mid_cas();
    logic [5:0] exp_t [0:3];
    exp_t = '{6'b011001, 6'b011111, 6'b001111, 6'b111001};
    apply_reset();
    bus.ba15 = 1'b0; bus.ba14 = 1'b0; bus.ba7 = 1'b1;
    bus.bmreq_n = 1'b0; bus.n_bwr = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (obs() !== 6'b001111) begin
      $display("FAIL mid_cas_pre got %b want %b", obs(), 6'b001111);
      n_err++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 6'b111001) begin
      $display("FAIL mid_cas_reset got %b want %b", obs(), 6'b111001);
      n_err++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL mid_cas_resume cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 2) begin bus.bmreq_n = 1'b1; bus.n_bwr = 1'b1; end
    end
  endtask

`ifdef MIOC_DMA_REFRESH_EN
  task automatic test_dma_refresh();
    int first;
    int second;
    first  = 0;
    second = 0;
    apply_reset();
    bus.dma_n = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.ras_n == 1'b0) begin first = k; break; end
    end
    n_cmp++;
    if (first != 61) begin
      $display("FAIL dma_first got %0d want %0d", first, 61);
      n_err++;
    end
    n_cmp++;
    if (obs() !== 6'b011001) begin
      $display("FAIL dma_rref got %b want %b", obs(), 6'b011001);
      n_err++;
    end
    for (int j = 1; j <= 200; j++) begin
      step();
      if (j >= 3 && bus.ras_n == 1'b0) begin second = j; break; end
    end
    n_cmp++;
    if (second != 61) begin
      $display("FAIL dma_restart got %0d want %0d", second, 61);
      n_err++;
    end
  endtask

  task automatic test_dma_freeze();
    int lows;
    int fall;
    lows = 0;
    fall = 0;
    apply_reset();
    bus.dma_n = 1'b0;
    repeat (30) step();
    bus.dma_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (bus.ras_n == 1'b0) lows++;
    end
    n_cmp++;
    if (lows != 0) begin
      $display("FAIL dma_freeze_ras got %0d want %0d", lows, 0);
      n_err++;
    end
    bus.dma_n = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.ras_n == 1'b0) begin fall = k; break; end
    end
    n_cmp++;
    if (fall != 31) begin
      $display("FAIL dma_freeze_resume got %0d want %0d", fall, 31);
      n_err++;
    end
  endtask

  task automatic test_pending_vs_read();
    logic [5:0] exp_t [0:7];
    exp_t = '{6'b011000, 6'b011000, 6'b111000, 6'b111001,
              6'b011011, 6'b011101, 6'b001101, 6'b111001};
    apply_reset();
    bus.dma_n = 1'b0;
    repeat (60) step();
    bus.ba15 = 1'b0; bus.ba14 = 1'b1; bus.ba7 = 1'b0;
    bus.bmreq_n = 1'b0; bus.brd_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (obs() !== exp_t[i]) begin
        $display("FAIL pending_read cyc%0d got %b want %b", i, obs(), exp_t[i]);
        n_err++;
      end
      if (i == 6) begin bus.bmreq_n = 1'b1; bus.brd_n = 1'b1; end
    end
    bus.dma_n = 1'b1;
  endtask
`else
  task automatic test_no_dma_refresh();
    int bad;
    bad = 0;
    apply_reset();
    bus.dma_n = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.ras_n !== 1'b1 || bus.wait_req_n !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL no_dma_refresh bad_cycles got %0d want %0d", bad, 0);
      n_err++;
    end
    bus.dma_n = 1'b1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read_bank();
    test_back_to_back();
    test_refresh_priority();
    test_refresh_rows();
    test_reset_mid_cas();
`ifdef MIOC_DMA_REFRESH_EN
    test_dma_refresh();
    test_dma_freeze();
    test_pending_vs_read();
`else
    test_no_dma_refresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_arb.md
DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 60, B_PHI cycles between internal refreshes while DMA_N is low.
REQ-002 SHALL have parameter REF_CNT_W, default 7, width of the refresh row counter.
REQ-003 B_PHI  in  1  system clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  reset; asynchronous, active-low.
REQ-005 BMREQ_N  in  1  memory request, active low.
REQ-006 BRFSH_N  in  1  Z80 refresh cycle, active low.
REQ-007 BRD_N, N_BWR  in  1 each  read and write strobes, active low.
REQ-008 DMA_N  in  1  6801 DMA owns the bus, active low.
REQ-009 BA15, BA14, BA7  in  1 each  bank select, row MSB source and column MSB source.
REQ-010 RAS_N, CAS1_N, CAS2_N  out  1 each  DRAM strobes; CAS1_N serves BA15=0 and CAS2_N serves BA15=1.
REQ-011 MUX  out  1  address mux select; 0 selects row, 1 selects column.
REQ-012 RA7  out  1  multiplexed RAM address MSB.
REQ-013 WAIT_REQ_N  out  1  stall request to the requester, active low.

Function
REQ-014 SHALL implement the states IDLE, ROW, COL, CAS, RREF, RHOLD and PRE, and SHALL register every output.
REQ-015 An access is BMREQ_N=0, BRFSH_N=1 and (BRD_N=0 or N_BWR=0), sampled in IDLE at edge N.
REQ-016 On an access: after edge N go to ROW (RAS_N=0, MUX=0, RA7=BA14); after edge N+1 go to COL (MUX=1, RA7=BA7); after edge N+2 go to CAS (the selected CASx_N=0).
REQ-017 CAS SHALL hold while BMREQ_N=0; when BMREQ_N=1 is sampled, go to PRE with all strobes high and MUX=0 for exactly one cycle, then to IDLE.
REQ-018 BA15 SHALL be latched in ROW; a bank change mid-cycle SHALL NOT move CAS to the other bank.
REQ-019 A Z80 refresh is BMREQ_N=0 and BRFSH_N=0 in IDLE: go to RREF (RAS_N=0, CAS high, RA7=ref_cnt MSB), then RHOLD for 1 cycle, then PRE.
REQ-020 ref_cnt SHALL increment by 1 on entry to PRE from RHOLD and wrap from 2^REF_CNT_W-1 to 0.
REQ-021 RA7 during refresh SHALL be a toggle bit that flips on each ref_cnt wrap, giving 256 rows.
REQ-022 If BRFSH_N and an access are both active in IDLE, refresh SHALL win.
REQ-023 A request arriving in PRE SHALL be served from IDLE on the next cycle; requests are never dropped while BMREQ_N is held low.

Reset
REQ-024 RST_N=0 SHALL force asynchronously: state=IDLE, RAS_N=CAS1_N=CAS2_N=1, MUX=0, RA7=0, WAIT_REQ_N=1, ref_cnt=0, toggle=0, interval timer=0, pending=0.
REQ-025 Reset asserted mid-CAS SHALL release all strobes in the same instant; after release, operation SHALL resume in IDLE at the next edge.

Configuration
REQ-026 With macro MIOC_DMA_REFRESH_EN defined: an interval timer counts B_PHI cycles while DMA_N=0, clears on any refresh, and sets pending at REF_INTERVAL.
REQ-027 With MIOC_DMA_REFRESH_EN defined: pending is served from IDLE as RREF ahead of any access, WAIT_REQ_N=0 while an access waits behind it, and the timer freezes and pending persists when DMA_N=1.
REQ-028 Without MIOC_DMA_REFRESH_EN: timer and pending SHALL be absent, WAIT_REQ_N SHALL be tied to 1, and refreshes SHALL come from BRFSH_N only.

Structure
REQ-029 Package mioc_pkg SHALL hold the state enum, REF_INTERVAL and REF_CNT_W defaults, and the bank-select constants.
REQ-030 Sub-module dram_ref_timer SHALL hold the interval timer, pending flag, ref_cnt and toggle, and SHALL be instantiated only under MIOC_DMA_REFRESH_EN, with ref_cnt and toggle kept in the parent otherwise.

Verification
REQ-031 Write: BMREQ_N=0, N_BWR=0, BA15=0 for 4 cycles -> RAS_N low 4 cycles, MUX high 3, CAS1_N low 2, CAS2_N stays 1, one PRE cycle.
REQ-032 Read with BA15=1, BA14=1, BA7=0 -> CAS2_N low, RA7=1 in ROW, RA7=0 in COL.
REQ-033 256 Z80 refreshes (BRFSH_N=0) -> RA7 is 0 for refreshes 1-128 and 1 for 129-256, and ref_cnt returns to 0.
REQ-034 MIOC_DMA_REFRESH_EN set, DMA_N=0, no requests for 60 cycles -> one RAS-only cycle, timer restarts from 0.
REQ-035 Pending refresh coincides with a read -> RREF runs first, WAIT_REQ_N=0 for 3 cycles, then ROW.
REQ-036 RST_N pulsed low during CAS -> RAS_N=CAS1_N=1 immediately, RA7=0, next access starts normally.
